cordic_result_sequencer: RTL and testbench
==========================================

Name: cordic_result_sequencer

Overview:
- Control and output stage directly downstream of the iterative CORDIC core.
- Launches one CORDIC operation on a start pulse and pulses the core's restart (the core's rst input) to load initial x/y/z.
- Counts the iteration cycles, then captures the core's x/y/z outputs and applies fixed-point gain compensation to x/y in circular mode.
- Presents the result on a valid/ready handshake and holds it stable until it is accepted.

Parameters:
- WHOLE_BIT_WIDTH, 3, integer bits of the signed fixed-point format.
- DECIMAL_BIT_WIDTH, 5, fractional bits.
- BIT_WIDTH, WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH, full word width.
- ITERATIONS, 8, core iteration cycles per operation (1..63).
- GAIN_COMP, 8'b000_10011, 1/K in the same Q format (19/32 = 0.59375), unsigned.
- CIRCULAR_CODE, 2'b01, coordinate_system value that enables gain compensation.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- start, input, 1, request a new operation; honoured only in IDLE.
- coordinate_system, input, 2, CORDIC mode; sampled when start is accepted.
- core_restart, output, 1, active-high one-cycle load/restart to the core.
- core_x, input, BIT_WIDTH, x_output of the core.
- core_y, input, BIT_WIDTH, y_output of the core.
- core_z, input, BIT_WIDTH, z_output of the core.
- busy, output, 1, high in every state except IDLE.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- x_result, output, BIT_WIDTH, compensated x.
- y_result, output, BIT_WIDTH, compensated y.
- z_result, output, BIT_WIDTH, z (never scaled).

Behaviour:
- Reset (rst==0 at a rising edge):
  - state IDLE, iteration counter 0.
  - core_restart, busy and out_valid all 0.
  - x_result, y_result and z_result all 0.
  - Reset overrides every other input, including mid-operation; on the following edge no core_restart is issued.
- All outputs are registered.
- IDLE:
  - start==1 → LOAD; latch coordinate_system into mode_q.
  - Otherwise stay in IDLE.
- LOAD:
  - core_restart==1 for exactly this one cycle.
  - Counter cleared to 0; → ITERATE.
- ITERATE:
  - Counter increments each cycle.
  - When counter==ITERATIONS-1 → CAPTURE, so ITERATE lasts exactly ITERATIONS cycles.
- CAPTURE:
  - On its exit edge, register the results and → DONE with out_valid=1.
  - z_result = core_z.
  - If mode_q==CIRCULAR_CODE: x_result = sat((signed core_x * GAIN_COMP) >>> DECIMAL_BIT_WIDTH). y_result is computed the same way from core_y.
  - Otherwise x_result = core_x and y_result = core_y.
- Arithmetic rules:
  - The product is 2*BIT_WIDTH bits signed; GAIN_COMP is zero-extended.
  - The shift is arithmetic, and the result is truncated toward −∞.
  - sat clamps to [−2^(BIT_WIDTH−1), 2^(BIT_WIDTH−1)−1].
- DONE:
  - out_valid==1; x/y/z_result held stable while out_ready==0.
  - On out_valid && out_ready at an edge → IDLE; out_valid is 0 the next cycle.
  - out_ready is allowed high in the first DONE cycle, giving a 1-cycle DONE.
- Latency: if start is sampled at edge E0, then:
  - core_restart is high during E0→E1.
  - out_valid rises after edge E(ITERATIONS+2), i.e. ITERATIONS+2 edges after the start sample (10 for the default).
- start while busy is ignored, including in the DONE cycle where the handshake completes. The next start is accepted no earlier than the first IDLE cycle.
- out_ready while out_valid==0 has no effect.
- Result registers hold their last value in IDLE/LOAD/ITERATE; they change only on the CAPTURE exit edge.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 and out_ready=1 → core_restart, busy and out_valid all 0, results 0x00; release rst → IDLE.
- Circular capture: start with coordinate_system=2'b01, core_x=0x20 (1.0), core_y=0xE0 (−1.0), core_z=0x0A → core_restart high for 1 cycle; out_valid rises exactly 10 edges after the start sample. x_result=0x13, y_result=0xED, z_result=0x0A.
- Non-circular pass-through: start with coordinate_system=2'b00, core_x=0x25, core_y=0x9C → x_result=0x25, y_result=0x9C, unscaled.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 while changing core_x/y/z and pulsing start → results stable, no core_restart; with out_ready=1, out_valid drops next cycle and the state is IDLE.
- Saturation (GAIN_COMP=8'h40, i.e. 2.0): core_x=0x60 (3.0) → x_result=0x7F; core_y=0xA0 (−3.0) → y_result=0x80.
- Mid-operation reset: assert rst=0 on ITERATE cycle 4 → next cycle IDLE with busy=0 and out_valid=0; a new start then completes with the normal 10-edge latency.

Source files
------------

// File: rtl/cordic_result_sequencer.sv
// Sequencer and output stage for an iterative CORDIC core.
// Launches one core operation per accepted start and counts the iteration cycles.
// It then captures x/y/z, applies gain compensation in circular mode, and holds
// the result on a valid/ready handshake until it is accepted.
module cordic_result_sequencer #(
  parameter int                   WHOLE_BIT_WIDTH   = 3,
  parameter int                   DECIMAL_BIT_WIDTH = 5,
  parameter int                   BIT_WIDTH         = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH,
  parameter int                   ITERATIONS        = 8,
  parameter logic [BIT_WIDTH-1:0] GAIN_COMP         = 8'b000_10011,
  parameter logic [1:0]           CIRCULAR_CODE     = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           coordinate_system,
  output logic                 core_restart,
  input  logic [BIT_WIDTH-1:0] core_x,
  input  logic [BIT_WIDTH-1:0] core_y,
  input  logic [BIT_WIDTH-1:0] core_z,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] x_result,
  output logic [BIT_WIDTH-1:0] y_result,
  output logic [BIT_WIDTH-1:0] z_result
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ITERATE = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

  // Signed value times unsigned gain, arithmetic shift back to the Q format
  // (floor rounding), then clamp to the signed range of the word.
  function automatic logic [BIT_WIDTH-1:0] gain_sat(input logic [BIT_WIDTH-1:0] v);
    logic signed [2*BIT_WIDTH-1:0] prod;
    logic signed [2*BIT_WIDTH-1:0] shr;
    prod = $signed({{BIT_WIDTH{v[BIT_WIDTH-1]}}, v}) *
           $signed({{BIT_WIDTH{1'b0}}, GAIN_COMP});
    shr  = prod >>> DECIMAL_BIT_WIDTH;
    if (shr[2*BIT_WIDTH-1:BIT_WIDTH-1] == {(BIT_WIDTH+1){shr[2*BIT_WIDTH-1]}}) begin
      gain_sat = shr[BIT_WIDTH-1:0];
    end else if (shr[2*BIT_WIDTH-1]) begin
      gain_sat = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    end else begin
      gain_sat = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    end
  endfunction

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 core_restart_q, core_restart_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0] x_result_q, x_result_d;
  logic [BIT_WIDTH-1:0] y_result_q, y_result_d;
  logic [BIT_WIDTH-1:0] z_result_q, z_result_d;

  // Next-state, counter, result-capture and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    x_result_d = x_result_q;
    y_result_d = y_result_q;
    z_result_d = z_result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          mode_d  = coordinate_system;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_d   = 6'd0;
        state_d = ITERATE;
      end
      ITERATE: begin
        if (cnt_q == LAST_ITER) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      CAPTURE: begin
        state_d    = DONE;
        z_result_d = core_z;
        if (mode_q == CIRCULAR_CODE) begin
          x_result_d = gain_sat(core_x);
          y_result_d = gain_sat(core_y);
        end else begin
          x_result_d = core_x;
          y_result_d = core_y;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are decoded from the next state so they appear registered
    // alongside the state they belong to.
    core_restart_d = (state_d == LOAD);
    busy_d         = (state_d != IDLE);
    out_valid_d    = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 6'd0;
      mode_q         <= 2'b00;
      core_restart_q <= 1'b0;
      busy_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      x_result_q     <= '0;
      y_result_q     <= '0;
      z_result_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      core_restart_q <= core_restart_d;
      busy_q         <= busy_d;
      out_valid_q    <= out_valid_d;
      x_result_q     <= x_result_d;
      y_result_q     <= y_result_d;
      z_result_q     <= z_result_d;
    end
  end

  assign core_restart = core_restart_q;
  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign x_result     = x_result_q;
  assign y_result     = y_result_q;
  assign z_result     = z_result_q;

endmodule

// File: tb/tb_cordic_result_sequencer.sv
// Directed bench for cordic_result_sequencer: table-driven operations on a
// default-gain instance and a gain-2.0 instance, plus reset, backpressure and
// mid-operation reset sequences.
module tb_cordic_result_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       out_ready;
  logic [1:0] coordinate_system;
  logic [7:0] core_x, core_y, core_z;
  logic       core_restart, busy, out_valid;
  logic [7:0] x_result, y_result, z_result;
  logic       core_restart2, busy2, out_valid2;
  logic [7:0] x2, y2, z2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] cx, cy, cz;
    logic [7:0] ex, ey;   // expected x/y, default gain 19/32
    logic [7:0] sx, sy;   // expected x/y, gain 2.0
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  cordic_result_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .coordinate_system(coordinate_system),
    .core_restart(core_restart), .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .x_result(x_result), .y_result(y_result), .z_result(z_result)
  );

  cordic_result_sequencer #(.GAIN_COMP(8'h40)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .coordinate_system(coordinate_system),
    .core_restart(core_restart2), .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready),
    .x_result(x2), .y_result(y2), .z_result(z2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue a start and return the number of edges after the start sample at
  // which out_valid was first seen (0 if it never rose within the budget).
  task automatic launch(input logic [1:0] mode, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] z, output int edges);
    @(negedge clk);
    start = 1'b1; coordinate_system = mode; core_x = x; core_y = y; core_z = z;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("restart_pulse", {31'd0, core_restart}, 32'd1);
    check("busy_load", {31'd0, busy}, 32'd1);
    edges = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) check("restart_one_cycle", {31'd0, core_restart}, 32'd0);
      if (out_valid) begin
        edges = n;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    vecs[0] = '{2'b01, 8'h20, 8'hE0, 8'h0A, 8'h13, 8'hED, 8'h40, 8'hC0};
    vecs[1] = '{2'b00, 8'h25, 8'h9C, 8'h11, 8'h25, 8'h9C, 8'h25, 8'h9C};
    vecs[2] = '{2'b01, 8'h7F, 8'h80, 8'h55, 8'h4B, 8'hB4, 8'h7F, 8'h80};
    vecs[3] = '{2'b10, 8'h80, 8'h7F, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'h7F};
    vecs[4] = '{2'b01, 8'h01, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h02, 8'hFE};
    vecs[5] = '{2'b01, 8'h60, 8'hA0, 8'h33, 8'h39, 8'hC7, 8'h7F, 8'h80};

    // Reset held with start and out_ready asserted.
    rst = 1'b0; start = 1'b1; out_ready = 1'b1; coordinate_system = 2'b01;
    core_x = 8'h5A; core_y = 8'h5A; core_z = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_ctrl", {29'd0, core_restart, busy, out_valid}, 32'd0);
      check("reset_results", {8'd0, x_result, y_result, z_result}, 32'd0);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {30'd0, busy, core_restart}, 32'd0);

    // Table-driven operations, consumer always ready (one-cycle DONE).
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].mode, vecs[i].cx, vecs[i].cy, vecs[i].cz, edges);
      check($sformatf("latency_v%0d", i), edges, 32'd10);
      check($sformatf("x_v%0d", i), {24'd0, x_result}, {24'd0, vecs[i].ex});
      check($sformatf("y_v%0d", i), {24'd0, y_result}, {24'd0, vecs[i].ey});
      check($sformatf("z_v%0d", i), {24'd0, z_result}, {24'd0, vecs[i].cz});
      check($sformatf("sat_valid_v%0d", i), {31'd0, out_valid2}, 32'd1);
      check($sformatf("sat_xy_v%0d", i), {16'd0, x2, y2}, {16'd0, vecs[i].sx, vecs[i].sy});
      @(negedge clk);
      check($sformatf("handshake_v%0d", i), {30'd0, out_valid, busy}, 32'd0);
    end

    // Backpressure: results held, start ignored while DONE.
    out_ready = 1'b0;
    launch(2'b01, 8'h20, 8'hE0, 8'h0A, edges);
    check("bp_latency", edges, 32'd10);
    for (int i = 0; i < 5; i++) begin
      core_x = 8'(i * 37); core_y = 8'(i * 11 + 3); core_z = 8'(i + 100);
      start = i[0];
      @(negedge clk);
      check("bp_hold_results", {8'd0, x_result, y_result, z_result}, 32'h0013ED0A);
      check("bp_ctrl", {29'd0, core_restart, busy, out_valid}, 32'd3);
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bp_release", {29'd0, core_restart, busy, out_valid}, 32'd0);
    @(negedge clk);
    check("bp_idle_stays", {30'd0, core_restart, busy}, 32'd0);
    check("bp_results_kept", {8'd0, x_result, y_result, z_result}, 32'h0013ED0A);

    // Mid-operation reset on ITERATE cycle 4.
    @(negedge clk);
    start = 1'b1; coordinate_system = 2'b01;
    core_x = 8'h20; core_y = 8'hE0; core_z = 8'h0A;
    @(negedge clk);
    start = 1'b0;
    check("mid_restart", {31'd0, core_restart}, 32'd1);
    repeat (4) @(negedge clk);
    check("mid_iterating", {30'd0, busy, out_valid}, 32'd2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_reset_ctrl", {29'd0, core_restart, busy, out_valid}, 32'd0);
    @(negedge clk);
    check("mid_no_restart", {30'd0, core_restart, busy}, 32'd0);
    launch(2'b00, 8'h25, 8'h9C, 8'h11, edges);
    check("mid_latency", edges, 32'd10);
    check("mid_results", {8'd0, x_result, y_result, z_result}, 32'h00259C11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
